// File: rtl/npu_axi_dma_copier.sv
// AXI4 DMA copier: reads one job's source via AR/R bursts into a beat buffer, then writes it out via AW/W/B.
// Optional NPU_DMA_ERR_EN adds rresp/bresp checking and a dma_resp_err flag alongside done.
module npu_axi_dma_copier #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_req_valid,
  output logic                  dma_req_ready,
  input  logic [63:0]           dma_req_src,
  input  logic [63:0]           dma_req_dst,
  input  logic [31:0]           dma_req_bytes,
  output logic                  dma_resp_done,
`ifdef NPU_DMA_ERR_EN
  output logic                  dma_resp_err,
`endif
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  output logic [63:0]           m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic                  m_axi_rlast,
`ifdef NPU_DMA_ERR_EN
  input  logic [1:0]            m_axi_rresp,
`endif
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [63:0]           m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  input  logic                  m_axi_bvalid,
`ifdef NPU_DMA_ERR_EN
  input  logic [1:0]            m_axi_bresp,
`endif
  output logic                  m_axi_bready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SZ     = $clog2(STRB_W);
  localparam int unsigned BEAT_W = $clog2(MAX_BURST);
  localparam logic [BEAT_W:0] MAX_LEN   = (BEAT_W+1)'(MAX_BURST);
  localparam logic [63:0]     ADDR_MASK = ~64'(STRB_W - 1);
  localparam logic [2:0]      AXI_SIZE  = 3'(SZ);

  typedef enum logic [2:0] {
    StIdle, StRdAddr, StRdData, StWrAddr, StWrData, StWrResp, StDone
  } state_e;

  state_e            state_q, state_d;
  logic [63:0]       src_q, dst_q;
  logic [32:0]       rem_q;
  logic [SZ-1:0]     tail_q;
  logic [BEAT_W-1:0] beat_q;
  logic [DATA_W-1:0] buf_q [MAX_BURST];

  logic [32:0]       req_beats;
  logic [12:0]       src_room, dst_room;
  logic [BEAT_W:0]   burst_len;
  logic [63:0]       burst_bytes;
  logic              beat_last, job_last;
  logic [STRB_W-1:0] tail_strb;
  logic              rd_err, wr_err, err_seen;
  logic              unused_rlast;

  // Beat counter is authoritative; rlast is not used to end a burst.
  assign unused_rlast = m_axi_rlast;

  assign req_beats = ({1'b0, dma_req_bytes} + 33'(STRB_W - 1)) >> SZ;
  // Beats left before the next 4KB boundary (1..4096/STRB_W).
  assign src_room  = (13'd4096 - {1'b0, src_q[11:0]}) >> SZ;
  assign dst_room  = (13'd4096 - {1'b0, dst_q[11:0]}) >> SZ;

  always_comb begin
    burst_len = (rem_q > 33'(MAX_LEN)) ? MAX_LEN : rem_q[BEAT_W:0];
    if (13'(burst_len) > src_room) burst_len = src_room[BEAT_W:0];
    if (13'(burst_len) > dst_room) burst_len = dst_room[BEAT_W:0];
  end

  assign burst_bytes = 64'(burst_len) << SZ;
  assign beat_last   = ({1'b0, beat_q} == burst_len - 1'b1);
  assign job_last    = (rem_q == 33'(burst_len));
  assign tail_strb   = {STRB_W{1'b1}} >> (STRB_W - 32'(tail_q));

`ifdef NPU_DMA_ERR_EN
  logic err_q;
  assign rd_err       = (m_axi_rresp != 2'b00);
  assign wr_err       = (m_axi_bresp != 2'b00);
  assign err_seen     = err_q;
  assign dma_resp_err = dma_resp_done & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle && dma_req_valid) begin
      err_q <= 1'b0;
    end else if (state_q == StRdData && m_axi_rvalid && rd_err) begin
      err_q <= 1'b1;
    end else if (state_q == StWrResp && m_axi_bvalid && wr_err) begin
      err_q <= 1'b1;
    end
  end
`else
  assign rd_err   = 1'b0;
  assign wr_err   = 1'b0;
  assign err_seen = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (dma_req_valid) state_d = (dma_req_bytes == 32'd0) ? StDone : StRdAddr;
      StRdAddr: if (m_axi_arready) state_d = StRdData;
      StRdData: if (m_axi_rvalid && beat_last) state_d = (err_seen || rd_err) ? StDone : StWrAddr;
      StWrAddr: if (m_axi_awready) state_d = StWrData;
      StWrData: if (m_axi_wready && beat_last) state_d = StWrResp;
      StWrResp: if (m_axi_bvalid) state_d = (job_last || err_seen || wr_err) ? StDone : StRdAddr;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q  <= '0;
      dst_q  <= '0;
      rem_q  <= '0;
      tail_q <= '0;
      beat_q <= '0;
    end else begin
      case (state_q)
        StIdle: if (dma_req_valid) begin
          src_q  <= dma_req_src & ADDR_MASK;
          dst_q  <= dma_req_dst & ADDR_MASK;
          rem_q  <= req_beats;
          tail_q <= dma_req_bytes[SZ-1:0];
          beat_q <= '0;
        end
        StRdData: if (m_axi_rvalid) beat_q <= beat_last ? '0 : beat_q + 1'b1;
        StWrData: if (m_axi_wready) beat_q <= beat_last ? '0 : beat_q + 1'b1;
        StWrResp: if (m_axi_bvalid) begin
          src_q <= src_q + burst_bytes;
          dst_q <= dst_q + burst_bytes;
          rem_q <= rem_q - 33'(burst_len);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StRdData && m_axi_rvalid) buf_q[beat_q] <= m_axi_rdata;
  end

  assign dma_req_ready = (state_q == StIdle);
  assign dma_resp_done = (state_q == StDone);

  assign m_axi_arvalid = (state_q == StRdAddr);
  assign m_axi_araddr  = m_axi_arvalid ? src_q : '0;
  assign m_axi_arlen   = m_axi_arvalid ? 8'(burst_len) - 8'd1 : '0;
  assign m_axi_arsize  = AXI_SIZE;
  assign m_axi_rready  = (state_q == StRdData);

  assign m_axi_awvalid = (state_q == StWrAddr);
  assign m_axi_awaddr  = m_axi_awvalid ? dst_q : '0;
  assign m_axi_awlen   = m_axi_awvalid ? 8'(burst_len) - 8'd1 : '0;
  assign m_axi_awsize  = AXI_SIZE;

  assign m_axi_wvalid  = (state_q == StWrData);
  assign m_axi_wdata   = m_axi_wvalid ? buf_q[beat_q] : '0;
  assign m_axi_wlast   = m_axi_wvalid & beat_last;
  // Only the final beat of the whole job carries a partial strobe.
  assign m_axi_wstrb   = !m_axi_wvalid ? '0 :
                         (job_last && beat_last && tail_q != '0) ? tail_strb : {STRB_W{1'b1}};
  assign m_axi_bready  = (state_q == StWrResp);

endmodule

// File: tb/tb_npu_axi_dma_copier.sv
// Scoreboard bench for npu_axi_dma_copier: a simple AXI slave answers bursts, a monitor checks them.
module tb_npu_axi_dma_copier;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         dma_req_valid, dma_req_ready, dma_resp_done;
  logic [63:0]  dma_req_src, dma_req_dst;
  logic [31:0]  dma_req_bytes;
  logic         m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [63:0]  m_axi_araddr, m_axi_awaddr;
  logic [7:0]   m_axi_arlen, m_axi_awlen;
  logic [2:0]   m_axi_arsize, m_axi_awsize;
  logic [255:0] m_axi_rdata, m_axi_wdata;
  logic         m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_wlast;
  logic [31:0]  m_axi_wstrb;
  logic         m_axi_bvalid, m_axi_bready;
`ifdef NPU_DMA_ERR_EN
  logic         dma_resp_err;
  logic [1:0]   m_axi_rresp = 2'b00;
  logic [1:0]   m_axi_bresp = 2'b00;
`endif

  always #5 clk = ~clk;

  npu_axi_dma_copier dut (
    .clk(clk), .rst(rst),
    .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready),
    .dma_req_src(dma_req_src), .dma_req_dst(dma_req_dst), .dma_req_bytes(dma_req_bytes),
    .dma_resp_done(dma_resp_done),
`ifdef NPU_DMA_ERR_EN
    .dma_resp_err(dma_resp_err), .m_axi_rresp(m_axi_rresp), .m_axi_bresp(m_axi_bresp),
`endif
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
    .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
    .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  typedef struct packed {logic [63:0] addr; logic [7:0] len;} ax_t;
  typedef struct packed {logic [255:0] data; logic [31:0] strb; logic last;} w_t;

  ax_t exp_ar[$], exp_aw[$];
  w_t  exp_w[$];
  int  tests = 0, fails = 0, done_seen = 0;
  bit  stall = 1'b0;

  function automatic logic [255:0] pat(input logic [63:0] b);
    return {b, ~b, b ^ 64'h5a5a_3c3c_0ff0_a5a5, b + 64'd12345};
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push_burst(input logic [63:0] s, input logic [63:0] d, input int l,
                            input bit final_b, input int tail);
    w_t w;
    exp_ar.push_back(ax_t'{s, 8'(l - 1)});
    exp_aw.push_back(ax_t'{d, 8'(l - 1)});
    for (int i = 0; i < l; i++) begin
      w.data = pat((s >> 5) + 64'(i));
      w.strb = 32'hFFFF_FFFF;
      if (final_b && i == l - 1 && tail != 0) w.strb = (32'd1 << tail) - 32'd1;
      w.last = (i == l - 1);
      exp_w.push_back(w);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic start_job(input logic [63:0] s, input logic [63:0] d, input logic [31:0] b);
    dma_req_src   = s;
    dma_req_dst   = d;
    dma_req_bytes = b;
    dma_req_valid = 1'b1;
    tick();
    dma_req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int base);
    int t = 0;
    while (done_seen == base && t < 5000) begin
      tick();
      t++;
    end
    chk({name, "_in_time"}, 256'(t < 5000), 256'(1));
    repeat (4) tick();
    chk({name, "_done_cnt"}, 256'(done_seen - base), 256'(1));
    chk({name, "_ar_left"}, 256'(exp_ar.size()), 256'(0));
    chk({name, "_aw_left"}, 256'(exp_aw.size()), 256'(0));
    chk({name, "_w_left"}, 256'(exp_w.size()), 256'(0));
  endtask

  // AXI slave: drives at negedge; a handshake happens at the next posedge when valid&&ready.
  initial begin : slave
    int r_left, r_idx, w_left;
    logic [63:0] r_base;
    bit b_pend;
    r_left = 0; r_idx = 0; w_left = 0; r_base = '0; b_pend = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rlast = 1'b0;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_left = 0; w_left = 0; b_pend = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0;
      end else begin
        if (r_left > 0) begin
          m_axi_rvalid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
          m_axi_rdata  = pat(r_base + 64'(r_idx));
          m_axi_rlast  = (r_left == 1);
          if (m_axi_rvalid && m_axi_rready) begin
            r_left--;
            r_idx++;
          end
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
        end
        if (r_left == 0) begin
          m_axi_arready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
          if (m_axi_arvalid && m_axi_arready) begin
            r_left = int'(m_axi_arlen) + 1;
            r_base = m_axi_araddr >> 5;
            r_idx  = 0;
          end
        end else begin
          m_axi_arready = 1'b0;
        end
        if (b_pend) begin
          if (!m_axi_bvalid) m_axi_bvalid = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
          if (m_axi_bvalid && m_axi_bready) b_pend = 1'b0;
        end else begin
          m_axi_bvalid = 1'b0;
        end
        if (w_left > 0) begin
          m_axi_wready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
          if (m_axi_wvalid && m_axi_wready) begin
            w_left--;
            if (w_left == 0) b_pend = 1'b1;
          end
        end else begin
          m_axi_wready = 1'b0;
        end
        if (w_left == 0 && !b_pend) begin
          m_axi_awready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
          if (m_axi_awvalid && m_axi_awready) w_left = int'(m_axi_awlen) + 1;
        end else begin
          m_axi_awready = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a handshake.
  initial begin : monitor
    ax_t e;
    w_t  we;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (m_axi_arvalid && m_axi_arready) begin
          chk("ar_expected", 256'(exp_ar.size() != 0), 256'(1));
          if (exp_ar.size() != 0) begin
            e = exp_ar.pop_front();
            chk("araddr", 256'(m_axi_araddr), 256'(e.addr));
            chk("arlen", 256'(m_axi_arlen), 256'(e.len));
            chk("arsize", 256'(m_axi_arsize), 256'(3'd5));
          end
        end
        if (m_axi_awvalid && m_axi_awready) begin
          chk("aw_expected", 256'(exp_aw.size() != 0), 256'(1));
          if (exp_aw.size() != 0) begin
            e = exp_aw.pop_front();
            chk("awaddr", 256'(m_axi_awaddr), 256'(e.addr));
            chk("awlen", 256'(m_axi_awlen), 256'(e.len));
            chk("awsize", 256'(m_axi_awsize), 256'(3'd5));
          end
        end
        if (m_axi_wvalid && m_axi_wready) begin
          chk("w_expected", 256'(exp_w.size() != 0), 256'(1));
          if (exp_w.size() != 0) begin
            we = exp_w.pop_front();
            chk("wdata", m_axi_wdata, we.data);
            chk("wstrb", 256'(m_axi_wstrb), 256'(we.strb));
            chk("wlast", 256'(m_axi_wlast), 256'(we.last));
          end
        end
        if (dma_resp_done) done_seen++;
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base, t;
    dma_req_valid = 1'b0; dma_req_src = '0; dma_req_dst = '0; dma_req_bytes = '0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ready", 256'(dma_req_ready), 256'(1));
    chk("rst_arvalid", 256'(m_axi_arvalid), 256'(0));
    chk("rst_awvalid", 256'(m_axi_awvalid), 256'(0));
    chk("rst_wvalid", 256'(m_axi_wvalid), 256'(0));
    chk("rst_done", 256'(dma_resp_done), 256'(0));
    chk("rst_araddr", 256'(m_axi_araddr), 256'(0));
    rst = 1'b0;
    tick();

    // 4 KB aligned copy: eight full bursts
    base = done_seen;
    for (int i = 0; i < 8; i++)
      push_burst(64'h30_0000_0000 + 64'(512 * i), 64'h30_0010_0000 + 64'(512 * i), 16, i == 7, 0);
    start_job(64'h30_0000_0000, 64'h30_0010_0000, 32'd4096);
    wait_done("t1_4k", base);

    // 40 bytes: two beats, 8-byte tail
    base = done_seen;
    push_burst(64'h1000, 64'h2000, 2, 1'b1, 8);
    start_job(64'h1000, 64'h2000, 32'd40);
    wait_done("t2_tail", base);

    // Source straddles a 4 KB boundary; a request while busy must be ignored
    base = done_seen;
    push_burst(64'h0F80, 64'h8000, 4, 1'b0, 0);
    push_burst(64'h1000, 64'h8080, 4, 1'b1, 0);
    start_job(64'h0F80, 64'h8000, 32'd256);
    dma_req_src = 64'hDEAD_0000; dma_req_dst = 64'hBEEF_0000; dma_req_bytes = 32'd64;
    dma_req_valid = 1'b1;
    chk("busy_ready", 256'(dma_req_ready), 256'(0));
    tick();
    tick();
    dma_req_valid = 1'b0;
    wait_done("t3_4kb", base);

    // Zero-byte job: done on the cycle after accept, no AXI traffic
    base = done_seen;
    dma_req_src = 64'h100; dma_req_dst = 64'h200; dma_req_bytes = 32'd0;
    dma_req_valid = 1'b1;
    tick();
    dma_req_valid = 1'b0;
    chk("zero_done_now", 256'(dma_resp_done), 256'(1));
    chk("zero_arvalid", 256'(m_axi_arvalid), 256'(0));
    tick();
    chk("zero_done_pulse", 256'(dma_resp_done), 256'(0));
    chk("zero_awvalid", 256'(m_axi_awvalid), 256'(0));
    repeat (3) tick();
    chk("zero_done_cnt", 256'(done_seen - base), 256'(1));

    // Random stalls, dst near a 4 KB boundary, 1000 bytes = 32 beats with 8-byte tail
    stall = 1'b1;
    base = done_seen;
    push_burst(64'h2000_0040, 64'h5000_0FC0, 2, 1'b0, 8);
    push_burst(64'h2000_0080, 64'h5000_1000, 16, 1'b0, 8);
    push_burst(64'h2000_0280, 64'h5000_1200, 14, 1'b1, 8);
    start_job(64'h2000_0040, 64'h5000_0FC0, 32'd1000);
    wait_done("t5_stall", base);
    stall = 1'b0;

    // Reset during WR_DATA drops the job without done
    base = done_seen;
    for (int i = 0; i < 8; i++)
      push_burst(64'h10_0000 + 64'(512 * i), 64'h20_0000 + 64'(512 * i), 16, i == 7, 0);
    start_job(64'h10_0000, 64'h20_0000, 32'd4096);
    t = 0;
    while (!m_axi_wvalid && t < 200) begin
      tick();
      t++;
    end
    chk("t6_reach_wdata", 256'(m_axi_wvalid), 256'(1));
    rst = 1'b1;
    tick();
    chk("t6_ready", 256'(dma_req_ready), 256'(1));
    chk("t6_wvalid", 256'(m_axi_wvalid), 256'(0));
    chk("t6_wdata", m_axi_wdata, 256'(0));
    chk("t6_wstrb", 256'(m_axi_wstrb), 256'(0));
    chk("t6_wlast", 256'(m_axi_wlast), 256'(0));
    chk("t6_arvalid", 256'(m_axi_arvalid), 256'(0));
    chk("t6_bready", 256'(m_axi_bready), 256'(0));
    chk("t6_done", 256'(dma_resp_done), 256'(0));
    tick();
    rst = 1'b0;
    exp_ar.delete();
    exp_aw.delete();
    exp_w.delete();
    repeat (3) tick();
    chk("t6_no_done", 256'(done_seen - base), 256'(0));

    // Fresh job after reset; low address bits are ignored
    base = done_seen;
    push_burst(64'h4_0000_0040, 64'h9000, 2, 1'b1, 8);
    start_job(64'h4_0000_0047, 64'h9005, 32'd40);
    wait_done("t7_after_rst", base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
